// File: rtl/mips_multicycle_core_if.sv
// Purpose: shared instruction/data memory port of the multi-cycle core.
// Latency: an access completes at the rising edge where mem_ready=1; any number of wait cycles.
// Backpressure: the master holds req/we/addr/wdata stable until it sees mem_ready; ready is ignored without req.
interface mips_multicycle_core_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// Purpose: multi-cycle MIPS-subset core (R-type, addi, lw, sw, beq, j; jal/jr when MC_LINK_EN is defined).
// Latency: FETCH to next FETCH is 4 cycles (R/addi/sw), 5 (lw), 3 (beq/j/jal/jr), plus one per memory wait cycle.
// Backpressure: FETCH and MEM stall while mem_ready=0 with the request held stable; HALT never requests memory.
module mips_multicycle_core #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    mips_multicycle_core_if.master io_mem,
    output logic [ADDR_W-1:0]      o_pc,
    output logic                   o_retire,
    output logic                   o_halted
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_SLT    = 6'b101010;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a, r_b, r_imm, r_alu, r_mdr;
    logic [DATA_W-1:0] r_regs [32];
    logic              r_halted;

    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd, w_wb_addr;
    logic              w_is_r, w_r_alu, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_j;
    logic              w_is_jal, w_is_jr, w_is_ctl, w_legal;
    logic [DATA_W-1:0] w_imm_ext, w_alu_res, w_wb_data;

    assign w_op      = r_ir[31:26];
    assign w_funct   = r_ir[5:0];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_imm_ext = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};

    assign w_is_r    = (w_op == OP_RTYPE);
    assign w_r_alu   = w_is_r && (w_funct == F_ADD || w_funct == F_SUB || w_funct == F_AND ||
                                  w_funct == F_OR  || w_funct == F_SLT);
    assign w_is_addi = (w_op == OP_ADDI);
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);
    assign w_is_beq  = (w_op == OP_BEQ);
    assign w_is_j    = (w_op == OP_J);
`ifdef MC_LINK_EN
    assign w_is_jal  = (w_op == 6'b000011);
    assign w_is_jr   = w_is_r && (w_funct == 6'b001000);
`else
    // Without the link feature jal/jr decode as illegal and halt the core.
    assign w_is_jal  = 1'b0;
    assign w_is_jr   = 1'b0;
`endif
    assign w_is_ctl  = w_is_beq || w_is_j || w_is_jal || w_is_jr;
    assign w_legal   = w_r_alu || w_is_addi || w_is_lw || w_is_sw || w_is_ctl;

    assign w_wb_addr = w_is_r  ? w_rd  : w_rt;
    assign w_wb_data = w_is_lw ? r_mdr : r_alu;

    // ALU: R-type ops use B, everything else (addi, lw/sw address) adds the immediate.
    always_comb begin
        w_alu_res = r_a + (w_is_r ? r_b : r_imm);
        if (w_is_r) begin
            case (w_funct)
                F_SUB:   w_alu_res = r_a - r_b;
                F_AND:   w_alu_res = r_a & r_b;
                F_OR:    w_alu_res = r_a | r_b;
                F_SLT:   w_alu_res = DATA_W'($signed(r_a) < $signed(r_b));
                default: w_alu_res = r_a + r_b;
            endcase
        end
    end

    // Port and status outputs follow the registered state; reset forces the idle values at once.
    assign io_mem.mem_req   = !i_reset && (r_state == S_FETCH || r_state == S_MEM);
    assign io_mem.mem_we    = !i_reset && (r_state == S_MEM) && w_is_sw;
    assign io_mem.mem_addr  = (r_state == S_MEM) ? r_alu[ADDR_W-1:0] : r_pc;
    assign io_mem.mem_wdata = r_b;
    assign o_pc             = i_reset ? RESET_PC : r_pc;
    assign o_halted         = !i_reset && r_halted;
    // sw retires in MEM on the completing cycle, so its pulse depends on mem_ready.
    assign o_retire         = !i_reset && ((r_state == S_WB) ||
                                           (r_state == S_EXEC && w_is_ctl) ||
                                           (r_state == S_MEM && w_is_sw && io_mem.mem_ready));

    // Control FSM together with PC, instruction/operand registers and register file.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_alu    <= '0;
            r_mdr    <= '0;
            r_halted <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (io_mem.mem_ready) begin
                        r_ir    <= io_mem.mem_rdata[31:0];
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_a     <= r_regs[w_rs];
                        r_b     <= r_regs[w_rt];
                        r_imm   <= w_imm_ext;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_alu   <= w_alu_res;
                    r_state <= S_FETCH;
                    if (w_r_alu || w_is_addi) begin
                        r_state <= S_WB;
                    end else if (w_is_lw || w_is_sw) begin
                        r_state <= S_MEM;
                    end else if (w_is_beq) begin
                        // PC already points past the branch, so the offset is relative to PC+1.
                        if (r_a == r_b) r_pc <= r_pc + r_imm[ADDR_W-1:0];
                    end else if (w_is_j) begin
                        r_pc <= r_ir[ADDR_W-1:0];
`ifdef MC_LINK_EN
                    end else if (w_is_jal) begin
                        r_regs[31] <= DATA_W'(r_pc);
                        r_pc       <= r_ir[ADDR_W-1:0];
                    end else if (w_is_jr) begin
                        r_pc <= r_a[ADDR_W-1:0];
`endif
                    end
                end
                S_MEM: begin
                    if (io_mem.mem_ready) begin
                        r_mdr   <= io_mem.mem_rdata;
                        r_state <= w_is_lw ? S_WB : S_FETCH;
                    end
                end
                S_WB: begin
                    if (w_wb_addr != 5'd0) r_regs[w_wb_addr] <= w_wb_data;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: instruction-level reference model checked on every access and retire,
// directed programs with hand-computed cycle counts and results, then randomized programs with random wait states.
// MC_LINK_EN selects whether jal/jr are modelled as legal.
module tb_mips_multicycle_core;
    localparam int         DW  = 32;
    localparam int         AW  = 8;
    localparam logic [7:0] RPC = 8'd5;
`ifdef MC_LINK_EN
    localparam bit LINK = 1'b1;
`else
    localparam bit LINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pc;
    logic       retire, halted;

    mips_multicycle_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mips_multicycle_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_mem  (bus.master),
        .o_pc    (pc),
        .o_retire(retire),
        .o_halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Memory seen by the DUT, and the model's own copy.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int wcnt = 0, fwait = 0, dwait = 0;
    bit rnd_wait = 0;

    // Reference model state.
    logic [7:0]  m_pc;
    logic [31:0] m_r [32];
    logic [31:0] m_ir, m_ld;
    int phase = 0, hcnt = 0, retire_cnt = 0, samp = 0, nf = 0;
    bit model_on = 0;
    int fa [32];
    int fc [32];
    bit pend = 0;
    logic [7:0]  s_addr;
    logic        s_we;
    logic [31:0] s_wd;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic bit legal(input logic [31:0] ir);
        case (ir[31:26])
            6'h00:                          return (ir[5:0] == 6'h20 || ir[5:0] == 6'h22 || ir[5:0] == 6'h24 ||
                                                    ir[5:0] == 6'h25 || ir[5:0] == 6'h2A || (LINK && ir[5:0] == 6'h08));
            6'h08, 6'h23, 6'h2B, 6'h04, 6'h02: return 1'b1;
            6'h03:                          return LINK;
            default:                        return 1'b0;
        endcase
    endfunction

    task automatic wr(input logic [4:0] idx, input logic [31:0] v);
        if (idx != 5'd0) m_r[idx] = v;
    endtask

    // Executes the instruction in m_ir against the architectural state.
    task automatic commit();
        logic [31:0] a, b, imm;
        logic [7:0]  npc;
        a   = m_r[m_ir[25:21]];
        b   = m_r[m_ir[20:16]];
        imm = {{16{m_ir[15]}}, m_ir[15:0]};
        npc = m_pc + 8'd1;
        case (m_ir[31:26])
            6'h00: case (m_ir[5:0])
                6'h20: wr(m_ir[15:11], a + b);
                6'h22: wr(m_ir[15:11], a - b);
                6'h24: wr(m_ir[15:11], a & b);
                6'h25: wr(m_ir[15:11], a | b);
                6'h2A: wr(m_ir[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                6'h08: npc = a[7:0];
                default: ;
            endcase
            6'h08: wr(m_ir[20:16], a + imm);
            6'h23: wr(m_ir[20:16], m_ld);
            6'h04: if (a == b) npc = npc + imm[7:0];
            6'h02: npc = m_ir[7:0];
            6'h03: begin
                m_r[31] = {24'd0, m_pc + 8'd1};
                npc     = m_ir[7:0];
            end
            default: ;
        endcase
        m_pc = npc;
    endtask

    // Memory slave: decides ready/rdata for the coming edge, away from the clock edge.
    always @(negedge clk) begin : slave_rd
        int tgt;
        tgt = (phase == 1) ? dwait : fwait;
        if (bus.mem_req) begin
            bus.mem_rdata = mem[bus.mem_addr];
            if (wcnt >= tgt) bus.mem_ready = 1'b1;
            else begin
                bus.mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            bus.mem_rdata = $urandom;
            bus.mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // Memory slave: commits writes and re-arms the wait counter at completing edges.
    always @(posedge clk) begin
        if (reset) wcnt = 0;
        else if (bus.mem_req && bus.mem_ready) begin
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            wcnt = 0;
            if (rnd_wait) begin
                fwait = $urandom_range(0, 2);
                dwait = $urandom_range(0, 3);
            end
        end
    end

    task automatic chk_stable();
        chk("hold_addr", bus.mem_addr, s_addr);
        chk("hold_we", bus.mem_we, s_we);
        chk("hold_wdata", bus.mem_wdata, s_wd);
    endtask

    // Compare process: every cycle, check accesses and retirements against the model.
    always @(negedge clk) begin : cmp
        logic [31:0] ea;
        #1;
        if (model_on && !reset) begin
            samp++;
            if (phase == 3) begin
                hcnt++;
                if (hcnt == 1) chk("halt_in_decode", halted, 0);
                else begin
                    chk("halted", halted, 1);
                    chk("halt_no_req", bus.mem_req, 0);
                end
            end else begin
                chk("not_halted", halted, 0);
                if (bus.mem_req && !bus.mem_ready) begin
                    if (pend) chk_stable();
                    pend   = 1;
                    s_addr = bus.mem_addr;
                    s_we   = bus.mem_we;
                    s_wd   = bus.mem_wdata;
                end else if (bus.mem_req && bus.mem_ready) begin
                    if (pend) chk_stable();
                    pend = 0;
                    if (phase == 0) begin
                        chk("fetch_addr", bus.mem_addr, m_pc);
                        chk("fetch_we", bus.mem_we, 0);
                        if (nf < 32) begin
                            fa[nf] = int'(bus.mem_addr);
                            fc[nf] = samp;
                        end
                        nf++;
                        m_ir = ref_mem[m_pc];
                        if (!legal(m_ir)) begin
                            phase = 3;
                            hcnt  = 0;
                        end else if (m_ir[31:26] == 6'h23 || m_ir[31:26] == 6'h2B) phase = 1;
                        else phase = 2;
                    end else if (phase == 1) begin
                        ea = m_r[m_ir[25:21]] + {{16{m_ir[15]}}, m_ir[15:0]};
                        chk("data_addr", bus.mem_addr, ea[7:0]);
                        chk("data_we", bus.mem_we, (m_ir[31:26] == 6'h2B));
                        if (m_ir[31:26] == 6'h2B) begin
                            chk("store_data", bus.mem_wdata, m_r[m_ir[20:16]]);
                            ref_mem[ea[7:0]] = m_r[m_ir[20:16]];
                        end else m_ld = ref_mem[ea[7:0]];
                        phase = 2;
                    end else begin
                        chk("unexpected_access", bus.mem_req, 0);
                    end
                end
                if (retire) begin
                    chk("retire_point", phase, 2);
                    commit();
                    phase = 0;
                    retire_cnt++;
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
    endtask

    task automatic put(input int a, input logic [31:0] w);
        mem[a]     = w;
        ref_mem[a] = w;
    endtask

    task automatic begin_reset();
        reset    = 1'b1;
        model_on = 0;
        repeat (2) @(posedge clk);
    endtask

    // Releases reset just after an edge so the following cycle is the first one out of reset.
    task automatic release_reset();
        @(posedge clk);
        #1;
        phase = 0; hcnt = 0; retire_cnt = 0; samp = 0; nf = 0; pend = 0;
        m_pc = RPC;
        for (int i = 0; i < 32; i++) m_r[i] = 32'd0;
        reset    = 1'b0;
        model_on = 1;
    endtask

    task automatic run(input int nret, input int maxcyc);
        int c;
        c = 0;
        while (retire_cnt < nret && !(phase == 3 && hcnt >= 4) && c < maxcyc) begin
            @(posedge clk);
            c++;
        end
        if (retire_cnt < nret && !(phase == 3 && hcnt >= 4)) chk("timeout_retires", retire_cnt, nret);
        #1;
    endtask

    function automatic logic [31:0] gen_instr();
        int k;
        logic [5:0] fn;
        k = $urandom_range(0, 99);
        case ($urandom_range(0, 4))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            default: fn = 6'h2A;
        endcase
        if (k < 30) return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), fn);
        if (k < 48) return enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
        if (k < 58) return enc_i(6'h23, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 255)));
        if (k < 68) return enc_i(6'h2B, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 255)));
        if (k < 80) return enc_i(6'h04, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 6) - 3));
        if (k < 86) return {6'h02, 26'($urandom_range(0, 255))};
`ifdef MC_LINK_EN
        if (k < 92) return {6'h03, 26'($urandom_range(0, 255))};
        if (k < 98) return enc_r($urandom_range(0, 7) | ((k & 1) ? 31 : 0), 0, 0, 6'h08);
`endif
        if (k == 99) return {6'h3F, 26'($urandom)};
        return enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 20)));
    endfunction

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int found, mism;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        // Arithmetic, store/load with data wait states, branches.
        begin_reset();
        clear_mem();
        put(5,  enc_i(6'h08, 0, 1, 16'd7));
        put(6,  enc_i(6'h08, 0, 2, 16'hFFFD));
        put(7,  enc_r(1, 2, 3, 6'h20));
        put(8,  enc_r(2, 1, 4, 6'h2A));
        put(9,  enc_i(6'h2B, 0, 1, 16'd2));
        put(10, enc_i(6'h23, 0, 5, 16'd2));
        put(11, enc_i(6'h04, 1, 2, 16'd5));
        put(12, enc_i(6'h04, 1, 1, 16'hFFFF));
        rnd_wait = 0; fwait = 0; dwait = 2;
        chk("reset_req", bus.mem_req, 0);
        chk("reset_pc", pc, 5);
        chk("reset_retire", retire, 0);
        release_reset();
        @(negedge clk); #2;
        chk("first_req", bus.mem_req, 1);
        chk("first_addr", bus.mem_addr, 5);
        chk("first_we", bus.mem_we, 0);
        @(negedge clk); #2;
        chk("pc_after_fetch", pc, 6);
        run(10, 400);
        chk("first_fetch_cycle", fc[0], 1);
        chk("four_instr_cycles", fc[4] - fc[0], 16);
        chk("sw_cycles", fc[5] - fc[4], 6);
        chk("lw_cycles", fc[6] - fc[5], 7);
        chk("beq_nt_cycles", fc[7] - fc[6], 3);
        chk("beq_nt_target", fa[7], 12);
        chk("beq_t_target", fa[8], 12);
        chk("beq_t_cycles", fc[9] - fc[8], 3);
        chk("sw_mem2", mem[2], 7);
        chk("r3", dut.r_regs[3], 4);
        chk("r4", dut.r_regs[4], 1);
        chk("r5", dut.r_regs[5], 7);

        // jal / jr.
        begin_reset();
        clear_mem();
        put(5,  {6'h03, 26'd20});
        put(20, enc_r(31, 0, 0, 6'h08));
        put(6,  32'hFC000000);
        dwait = 0;
        release_reset();
`ifdef MC_LINK_EN
        run(2, 200);
        repeat (4) @(posedge clk);
        chk("jal_target", fa[1], 20);
        chk("jal_cycles", fc[1] - fc[0], 3);
        chk("jr_target", fa[2], 6);
        chk("jr_cycles", fc[2] - fc[1], 3);
        chk("r31_link", dut.r_regs[31], 6);
        chk("halt_after_jr", halted, 1);
`else
        repeat (8) @(negedge clk);
        #2;
        chk("jal_illegal_halt", halted, 1);
        chk("jal_no_req", bus.mem_req, 0);
        chk("jal_one_fetch", nf, 1);
`endif

        // Illegal opcode halts after DECODE.
        begin_reset();
        clear_mem();
        put(5, 32'hFC000000);
        release_reset();
        @(negedge clk); #2;
        chk("ill_fetch_req", bus.mem_req, 1);
        @(negedge clk); #2;
        chk("ill_decode_halted", halted, 0);
        @(negedge clk); #2;
        chk("ill_halted", halted, 1);
        chk("ill_no_req", bus.mem_req, 0);
        repeat (5) @(negedge clk);
        #2;
        chk("ill_still_no_req", bus.mem_req, 0);

        // Reset in the middle of a waiting lw.
        begin_reset();
        clear_mem();
        put(5, enc_i(6'h08, 0, 1, 16'd7));
        put(6, enc_i(6'h23, 0, 5, 16'd2));
        put(2, 32'd9);
        dwait = 5;
        release_reset();
        found = 0;
        for (int c = 0; c < 60 && found == 0; c++) begin
            @(negedge clk); #2;
            if (phase == 1 && bus.mem_req && !bus.mem_ready) found = 1;
        end
        chk("lw_wait_seen", found, 1);
        begin_reset();
        chk("rst_req_low", bus.mem_req, 0);
        chk("rst_halted_low", halted, 0);
        chk("rst_r5", dut.r_regs[5], 0);
        chk("rst_r1", dut.r_regs[1], 0);
        dwait = 0;
        release_reset();
        @(negedge clk); #2;
        chk("refetch_req", bus.mem_req, 1);
        chk("refetch_addr", bus.mem_addr, 5);
        run(2, 100);
        chk("refetch_r5", dut.r_regs[5], 9);

        // Randomized programs with random wait states.
        for (int t = 0; t < 12; t++) begin
            begin_reset();
            for (int i = 0; i < 256; i++) put(i, gen_instr());
            rnd_wait = 1;
            fwait = $urandom_range(0, 2);
            dwait = $urandom_range(0, 3);
            release_reset();
            run(150, 3000);
            for (int k = 0; k < 32; k++) chk($sformatf("rand%0d_r%0d", t, k), dut.r_regs[k], m_r[k]);
            mism = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
            chk($sformatf("rand%0d_mem_image", t), mism, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multi-cycle MIPS-subset processor core with its own control FSM, register file and ALU. It fetches and executes instructions one at a time through a single shared, handshaked memory port that tolerates wait states. It supports R-type ALU ops, addi, lw, sw, beq, j, and optionally jal/jr. Word-addressed like the existing single-cycle datapath: PC advances by 1 per instruction.

## Interface
- DATA_W, 32: register/ALU/memory data width; must be ≥32. Instruction = mem_rdata[31:0].
- ADDR_W, 8: word-address width of PC and memory port.
- RESET_PC, 0: PC value loaded on reset.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (sw), 0 = read.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1.
- mem_ready  in  1  access completes at this edge.
- pc  out  ADDR_W  current PC.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  sticky illegal-opcode halt.

## Operation
- States:
  - FETCH: req PC; on ready latch IR, PC<=PC+1.
  - DECODE: A<=R[rs], B<=R[rt], IMM<=signext(IR[15:0]) to DATA_W.
  - EXEC
  - MEM
  - WB
  - HALT
- R-type, op 000000, funct:
  - add 100000
  - sub 100010
  - and 100100
  - or 100101
  - slt 101010 (signed, result 1/0)
  - jr 001000
- Other opcodes:
  - addi 001000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - jal 000011
- Paths:
  - R/addi: EXEC computes ALUOUT -> WB writes rd (R) / rt (addi) -> FETCH.
  - lw/sw: EXEC ALUOUT = A+IMM; mem_addr = ALUOUT[ADDR_W-1:0]. In MEM, lw writes rt in MEM->WB, sw writes B.
  - beq: in EXEC, if A==B, PC<=PC+IMM[ADDR_W-1:0]. PC has already been incremented, so target = old PC+1+imm. Back to FETCH.
  - j: in EXEC, PC<=IR[ADDR_W-1:0].
  - jal: in EXEC, R[31]<=PC (= old PC+1, zero-extended), PC<=IR[ADDR_W-1:0].
  - jr: in EXEC, PC<=A[ADDR_W-1:0].
- Any unlisted opcode/funct -> HALT. HALT never requests memory and holds until reset.
- Register file: 32 x DATA_W. R[0] reads 0 and writes to it are dropped.
- Arithmetic wraps modulo 2^DATA_W. Address/PC arithmetic wraps modulo 2^ADDR_W.
- retire pulses in the last state of each instruction, for one cycle.

## Timing
- Handshake:
  - mem_req/mem_we/mem_addr/mem_wdata are stable from assertion until the edge where mem_ready=1.
  - mem_ready is ignored when mem_req=0.
  - The access completes at that edge. Each extra cycle of ready=0 adds one cycle in FETCH/MEM.
- Zero-wait latencies, FETCH to next FETCH:
  - R/addi/sw: 4 cycles.
  - lw: 5 cycles.
  - beq/j/jal/jr: 3 cycles.
- Reset:
  - While reset=1: mem_req=0, mem_we=0, retire=0, halted=0, pc=RESET_PC, all registers 0, state=FETCH.
  - First request occurs in the cycle after reset deasserts.
  - Reset mid-access abandons the access with no register/PC update.
- Simultaneous: a write to register X in WB and a read of X in DECODE never coincide (multi-cycle). jal writing R[31] with rs=31 is not a hazard.

## Configuration
- MC_LINK_EN defined: jal and jr execute as specified.
- MC_LINK_EN undefined: the jal opcode and the jr funct are illegal and enter HALT. The R[31] link write logic is not built.

## Test plan
- Reset with RESET_PC=5, zero-wait memory -> first mem_req with mem_addr=5, mem_we=0. pc=6 after fetch.
- addi r1,r0,7; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 -> r3=4, r4=1. 4 retire pulses, 16 cycles.
- sw r1,2(r0) then lw r5,2(r0), with mem_ready delayed 2 cycles per access -> write at addr 2 data 7, r5=7. Address/data held stable during the wait. lw takes 7 cycles.
- beq r1,r1,-1 at PC=10 -> next fetch at 10. beq r1,r2 not taken -> next fetch at 11.
- With MC_LINK_EN: jal 20 at PC=3 -> r31=4, fetch at 20. Then jr r31 -> fetch at 4. Without MC_LINK_EN: jal -> halted=1, mem_req stays 0.
- Opcode 111111 -> halted=1 after DECODE. Reset asserted mid lw wait -> no r-write, halted=0, refetch at RESET_PC.
